// File: rtl/prio_req_encoder.sv
// Registered N-line request encoder with sticky pending bits and valid/ready output.
// Define PRIO_REQ_ENCODER_CNT_EN to add the pend_cnt population-count output.
module prio_req_encoder #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     req_en,
  input  logic             rr_mode,
  input  logic             flush,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
`ifdef PRIO_REQ_ENCODER_CNT_EN
  output logic [N-1:0]     pend,
  output logic [$clog2(N+1)-1:0] pend_cnt
`else
  output logic [N-1:0]     pend
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [N-1:0]     ONE  = N'(1);

  logic [N-1:0]     pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     new_req;
  logic [N-1:0]     clr;
  logic [N-1:0]     cand;
  logic [N-1:0]     low_mask;
  logic [N-1:0]     low_cand;
  logic [IDX_W-1:0] sel;
  logic             acc;
  logic             load;

  function automatic logic [IDX_W-1:0] hi_idx(input logic [N-1:0] v);
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) hi_idx = IDX_W'(i);
    end
  endfunction

  // Round-robin: highest candidate at or below ptr, else wrap to highest overall.
  always_comb begin
    new_req = req & req_en;
    acc     = out_valid_q & out_ready;
    clr     = acc ? (ONE << out_idx_q) : '0;
    cand    = (pend_q & ~clr) | new_req;
    load    = !out_valid_q | acc;
    for (int i = 0; i < N; i++) begin
      low_mask[i] = (IDX_W'(i) <= ptr_q);
    end
    low_cand = cand & low_mask;
    if (rr_mode && (|low_cand)) sel = hi_idx(low_cand);
    else                        sel = hi_idx(cand);
  end

  always_comb begin
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    ptr_d       = ptr_q;
    if (flush) begin
      pend_d      = new_req;
      out_valid_d = 1'b0;
    end else if (load) begin
      if (|cand) begin
        out_valid_d = 1'b1;
        out_idx_d   = sel;
        pend_d      = cand & ~(ONE << sel);
        if (rr_mode) ptr_d = (sel == '0) ? LAST : sel - 1'b1;
      end else begin
        out_valid_d = 1'b0;
        pend_d      = '0;
      end
    end else begin
      pend_d = pend_q | new_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ptr_q       <= LAST;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pend      = pend_q;

`ifdef PRIO_REQ_ENCODER_CNT_EN
  localparam int CNT_W = $clog2(N + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + CNT_W'(pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign pend_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prio_req_encoder.sv
// Random and directed checks of prio_req_encoder against a behavioural model.
module tb_prio_req_encoder;

  localparam int N = 16;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_en = '1;
  logic             rr_mode = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     pend;
`ifdef PRIO_REQ_ENCODER_CNT_EN
  logic [$clog2(N+1)-1:0] pend_cnt;
`endif

  int checks = 0;
  int failures = 0;

  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_idx;
  int         m_ptr;

  prio_req_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_en    (req_en),
    .rr_mode   (rr_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
`ifdef PRIO_REQ_ENCODER_CNT_EN
    .pend      (pend),
    .pend_cnt  (pend_cnt)
`else
    .pend      (pend)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Walk downward from the pointer with wraparound; fixed mode takes the top bit.
  function automatic int pick(bit [N-1:0] c, bit rr, int p);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j = (p - k + N) % N;
        if (c[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [N-1:0] nw;
    bit [N-1:0] c;
    int s;
    if (rst) begin
      m_pend = '0; m_valid = 0; m_idx = 0; m_ptr = N - 1;
      return;
    end
    nw = req & req_en;
    if (flush) begin
      m_pend = nw;
      m_valid = 0;
    end else if (!m_valid || out_ready) begin
      c = m_pend;
      if (m_valid && out_ready) c[m_idx] = 1'b0;
      c |= nw;
      s = pick(c, rr_mode, m_ptr);
      if (s >= 0) begin
        m_valid = 1;
        m_idx = s;
        c[s] = 1'b0;
        m_pend = c;
        if (rr_mode) m_ptr = (s + N - 1) % N;
      end else begin
        m_valid = 0;
        m_pend = '0;
      end
    end else begin
      m_pend |= nw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", 64'(out_valid), 64'(m_valid));
    chk("idx", 64'(out_idx), 64'(m_idx));
    chk("pend", 64'(pend), 64'(m_pend));
`ifdef PRIO_REQ_ENCODER_CNT_EN
    chk("cnt", 64'(pend_cnt), 64'($countones(m_pend)));
`endif
  endtask

  task automatic do_reset();
    rst = 1; req = '0; flush = 0;
    tick();
    rst = 0;
  endtask

  int drain_exp[8] = '{15, 13, 10, 8, 7, 5, 2, 0};
  int rr_exp[4] = '{9, 4, 9, 4};

  initial begin
    rst = 1;
    tick();
    tick();
    rst = 0; req = '0;
    tick();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_pend", 64'(pend), 64'd0);
    chk("idle_idx", 64'(out_idx), 64'd0);
    req = 16'h8001; out_ready = 0;
    tick();
    req = '0;
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_idx", 64'(out_idx), 64'd15);
    chk("first_pend", 64'(pend), 64'h0001);

    do_reset();
    req = 16'h0009; out_ready = 0;
    tick();
    req = 16'h4000;
    tick();
    req = '0;
    chk("hold_idx", 64'(out_idx), 64'd3);
    out_ready = 1;
    tick();
    chk("after_hold", 64'(out_idx), 64'd14);
    tick();
    chk("then_zero", 64'(out_idx), 64'd0);
    tick();
    chk("hold_empty", 64'(out_valid), 64'd0);

    do_reset();
    out_ready = 1; req = 16'hA5A5;
    for (int i = 0; i < 8; i++) begin
      tick();
      req = '0;
      chk("drain_idx", 64'(out_idx), 64'(drain_exp[i]));
    end
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_pend", 64'(pend), 64'd0);

    do_reset();
    rr_mode = 1; req = 16'h0210; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_idx", 64'(out_idx), 64'(rr_exp[i]));
    end
    do_reset();
    rr_mode = 0; req = 16'h0210;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fixed_idx", 64'(out_idx), 64'd9);
    end

    do_reset();
    req_en = 16'hFFBF; req = 16'h0040;
    tick();
    req = '0;
    tick();
    chk("mask_valid", 64'(out_valid), 64'd0);
    chk("mask_pend", 64'(pend), 64'd0);
    req_en = '1; out_ready = 0; req = 16'h0006;
    tick();
    chk("pre_flush", 64'(pend), 64'h0002);
    req = 16'h0020; flush = 1;
    tick();
    flush = 0; req = '0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pend", 64'(pend), 64'h0020);
    tick();
    chk("flush_idx", 64'(out_idx), 64'd5);

    do_reset();
    out_ready = 0; req = 16'h01F0;
    tick();
    req = '0;
    chk("mid_pend", 64'(pend), 64'h00F0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
`ifdef PRIO_REQ_ENCODER_CNT_EN
    chk("rst_cnt", 64'(pend_cnt), 64'd0);
    req = 16'hA5A5;
    tick();
    req = '0;
    chk("cnt_a5a5", 64'(pend_cnt), 64'd7);
    do_reset();
`endif
    rr_mode = 1; req = 16'h8001;
    tick();
    req = '0;
    chk("ptr_reset", 64'(out_idx), 64'd15);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 29) == 0);
      req = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      req_en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      if (i % 100 == 0) rr_mode = ~rr_mode;
      else if ($urandom_range(0, 19) == 0) rr_mode = ~rr_mode;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
